bfloat16_mul: RTL and testbench

//   Pipelined BFloat16 (1s/8e/7m, bias 127) multiplier, unsigned-exponent datapath.

---
 rtl/bfloat16_mul_if.sv | 21 ++
 rtl/bfloat16_mul.sv | 121 ++++++++++++
 tb/tb_bfloat16_mul.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/bfloat16_mul_if.sv
// Operand and result bundle for the 2-stage BF16 multiplier.
// The master drives operands; the slave (the multiplier) returns the product and debug fields.
interface bfloat16_mul_if;
    logic [15:0] flp_a;
    logic [15:0] flp_b;
    logic [8:0]  exponent;
    logic [8:0]  exp_unbiased;
    logic [9:0]  exp_sum;
    logic [6:0]  prod;
    logic [15:0] sum;

    modport master (
        output flp_a, flp_b,
        input  exponent, exp_unbiased, exp_sum, prod, sum
    );

    modport slave (
        input  flp_a, flp_b,
        output exponent, exp_unbiased, exp_sum, prod, sum
    );
endinterface

// File: rtl/bfloat16_mul.sv
// Free-running 2-stage BFloat16 multiplier: stage 1 unpacks and multiplies mantissas,
// stage 2 normalizes, rounds to nearest even, resolves special operands and packs.
module bfloat16_mul (
    input  logic          clk,
    input  logic          rst,
    bfloat16_mul_if.slave bus
);
    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 7;
    localparam int unsigned BIAS  = 127;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    // Stage 1
    logic             s1_sign_d, s1_sign_q;
    logic [EXP_W-1:0] s1_a_exp_d, s1_a_exp_q, s1_b_exp_d, s1_b_exp_q;
    logic [MAN_W-1:0] s1_a_man_d, s1_a_man_q, s1_b_man_d, s1_b_man_q;
    logic [9:0]       s1_exp_sum_d, s1_exp_sum_q;
    logic [15:0]      s1_mant_d, s1_mant_q;

    always_comb begin
        s1_sign_d    = bus.flp_a[15] ^ bus.flp_b[15];
        s1_a_exp_d   = bus.flp_a[14:7];
        s1_b_exp_d   = bus.flp_b[14:7];
        s1_a_man_d   = bus.flp_a[6:0];
        s1_b_man_d   = bus.flp_b[6:0];
        s1_exp_sum_d = {2'b00, s1_a_exp_d} + {2'b00, s1_b_exp_d};
        s1_mant_d    = {8'h00, 1'b1, s1_a_man_d} * {8'h00, 1'b1, s1_b_man_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sign_q    <= 1'b0;
            s1_a_exp_q   <= '0;
            s1_b_exp_q   <= '0;
            s1_a_man_q   <= '0;
            s1_b_man_q   <= '0;
            s1_exp_sum_q <= '0;
            s1_mant_q    <= '0;
        end else begin
            s1_sign_q    <= s1_sign_d;
            s1_a_exp_q   <= s1_a_exp_d;
            s1_b_exp_q   <= s1_b_exp_d;
            s1_a_man_q   <= s1_a_man_d;
            s1_b_man_q   <= s1_b_man_d;
            s1_exp_sum_q <= s1_exp_sum_d;
            s1_mant_q    <= s1_mant_d;
        end
    end

    // Stage 2
    logic [MAN_W-1:0] frac;
    logic             guard, sticky, shift, round_up, round_carry;
    logic [MAN_W:0]   frac_rnd;
    logic [10:0]      exp_wide;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [8:0]       exponent_d, exponent_q, exp_unbiased_d, exp_unbiased_q;
    logic [9:0]       exp_sum_q;
    logic [6:0]       prod_d, prod_q;
    logic [15:0]      sum_d, sum_q;

    always_comb begin
        shift  = s1_mant_q[15];
        frac   = shift ? s1_mant_q[14:8] : s1_mant_q[13:7];
        guard  = shift ? s1_mant_q[7] : s1_mant_q[6];
        sticky = shift ? |s1_mant_q[6:0] : |s1_mant_q[5:0];

        round_up    = guard & (sticky | frac[0]);
        frac_rnd    = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
        round_carry = frac_rnd[MAN_W];
        prod_d      = frac_rnd[MAN_W-1:0];

        // Biased sum kept unsigned and wide so range checks never see a wrapped value.
        exp_wide       = {1'b0, s1_exp_sum_q} + {10'd0, shift} + {10'd0, round_carry};
        exp_unbiased_d = s1_exp_sum_q[8:0] - 9'(BIAS);
        exponent_d     = exp_wide[8:0] - 9'(BIAS);

        a_nan  = (s1_a_exp_q == EXP_MAX) && (s1_a_man_q != '0);
        b_nan  = (s1_b_exp_q == EXP_MAX) && (s1_b_man_q != '0);
        a_inf  = (s1_a_exp_q == EXP_MAX) && (s1_a_man_q == '0);
        b_inf  = (s1_b_exp_q == EXP_MAX) && (s1_b_man_q == '0);
        a_zero = (s1_a_exp_q == '0);
        b_zero = (s1_b_exp_q == '0);

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            sum_d = 16'h7FC0;
        end else if (a_inf || b_inf) begin
            sum_d = {s1_sign_q, EXP_MAX, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            sum_d = {s1_sign_q, 15'h0000};
        end else if (exp_wide >= 11'(255 + BIAS)) begin
            sum_d = {s1_sign_q, EXP_MAX, {MAN_W{1'b0}}};
        end else if (exp_wide <= 11'(BIAS)) begin
            sum_d = {s1_sign_q, 15'h0000};
        end else begin
            sum_d = {s1_sign_q, exponent_d[EXP_W-1:0], prod_d};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exponent_q     <= '0;
            exp_unbiased_q <= '0;
            exp_sum_q      <= '0;
            prod_q         <= '0;
            sum_q          <= '0;
        end else begin
            exponent_q     <= exponent_d;
            exp_unbiased_q <= exp_unbiased_d;
            exp_sum_q      <= s1_exp_sum_q;
            prod_q         <= prod_d;
            sum_q          <= sum_d;
        end
    end

    assign bus.exponent     = exponent_q;
    assign bus.exp_unbiased = exp_unbiased_q;
    assign bus.exp_sum      = exp_sum_q;
    assign bus.prod         = prod_q;
    assign bus.sum          = sum_q;
endmodule

// File: tb/tb_bfloat16_mul.sv
// Table-driven bench for bfloat16_mul: hand-computed vectors go through a scoreboard
// keyed on the cycle each result is due, plus streaming and mid-cycle reset sequences.
module tb_bfloat16_mul;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    bfloat16_mul_if bus ();

    bfloat16_mul dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [9:0]  es;
        logic [8:0]  eu;
        logic [8:0]  ex;
        logic [6:0]  prod;
        logic [15:0] sum;
        int          idx;
        int          due;
    } vec_t;

    vec_t tbl[20];
    int   ntbl = 0;
    vec_t sb[$];

    task automatic add(input logic [15:0] a, input logic [15:0] b, input logic [9:0] es,
                       input logic [8:0] eu, input logic [8:0] ex, input logic [6:0] prod,
                       input logic [15:0] sum);
        tbl[ntbl] = '{a, b, es, eu, ex, prod, sum, ntbl, 0};
        ntbl++;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".exponent"}, 16'(bus.exponent), 16'h0);
        chk({tag, ".exp_unbiased"}, 16'(bus.exp_unbiased), 16'h0);
        chk({tag, ".exp_sum"}, 16'(bus.exp_sum), 16'h0);
        chk({tag, ".prod"}, 16'(bus.prod), 16'h0);
        chk({tag, ".sum"}, bus.sum, 16'h0);
    endtask

    // One cycle: compare any result due now, then optionally drive and enqueue a vector.
    task automatic step(input bit drive, input vec_t v);
        vec_t e;
        @(negedge clk);
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk($sformatf("v%0d.due", e.idx), 16'(cyc), 16'(e.due));
            chk($sformatf("v%0d.exp_sum", e.idx), 16'(bus.exp_sum), 16'(e.es));
            chk($sformatf("v%0d.exp_unbiased", e.idx), 16'(bus.exp_unbiased), 16'(e.eu));
            chk($sformatf("v%0d.exponent", e.idx), 16'(bus.exponent), 16'(e.ex));
            chk($sformatf("v%0d.prod", e.idx), 16'(bus.prod), 16'(e.prod));
            chk($sformatf("v%0d.sum", e.idx), bus.sum, e.sum);
        end
        if (drive) begin
            bus.flp_a = v.a;
            bus.flp_b = v.b;
            e = v;
            e.due = cyc + 2;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        vec_t none;
        none = '{16'h0, 16'h0, 10'h0, 9'h0, 9'h0, 7'h0, 16'h0, -1, 0};
        for (int i = 0; i < 4; i++) step(1'b0, none);
        chk("scoreboard_empty", 16'(sb.size()), 16'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //   a         b         exp_sum   exp_unb   exponent  prod   sum
        add(16'hAAAA, 16'hCCCC, 10'd238, 9'd111,  9'd112,  7'h07, 16'h3807);
        add(16'h3F80, 16'h4000, 10'd255, 9'd128,  9'd128,  7'h00, 16'h4000);
        add(16'h3FC0, 16'h3FC0, 10'd254, 9'd127,  9'd128,  7'h10, 16'h4010);
        // frac 0x41 is odd at the tie, so nearest-even rounds up to 0x42
        add(16'h3F81, 16'h3FC0, 10'd254, 9'd127,  9'd127,  7'h42, 16'h3FC2);
        // frac 0x44 is even at the tie, so it stays
        add(16'h3F83, 16'h3FC0, 10'd254, 9'd127,  9'd127,  7'h44, 16'h3FC4);
        // P=0x7FF9: rounding carries out of frac into the exponent
        add(16'h3FB5, 16'h3FB5, 10'd254, 9'd127,  9'd128,  7'h00, 16'h4000);
        add(16'h0000, 16'hC000, 10'd128, 9'd1,    9'd1,    7'h00, 16'h8000);
        add(16'h7F00, 16'h7F00, 10'd508, 9'h17D,  9'h17D,  7'h00, 16'h7F80);
        add(16'h7FC0, 16'h3F80, 10'd382, 9'h0FF,  9'h0FF,  7'h40, 16'h7FC0);
        add(16'h7F80, 16'h0000, 10'd255, 9'd128,  9'd128,  7'h00, 16'h7FC0);
        add(16'h7F80, 16'hC000, 10'd383, 9'h100,  9'h100,  7'h00, 16'hFF80);
        add(16'hBF80, 16'h3F80, 10'd254, 9'd127,  9'd127,  7'h00, 16'hBF80);
        add(16'h7F00, 16'h4000, 10'd382, 9'd255,  9'd255,  7'h00, 16'h7F80);
        add(16'h7F00, 16'h3F80, 10'd381, 9'd254,  9'd254,  7'h00, 16'h7F00);
        add(16'h0080, 16'h3F80, 10'd128, 9'd1,    9'd1,    7'h00, 16'h0080);
        add(16'h0080, 16'h3F00, 10'd127, 9'd0,    9'd0,    7'h00, 16'h0000);
        add(16'h0080, 16'h0080, 10'd2,   9'h183,  9'h183,  7'h00, 16'h0000);
        add(16'h8001, 16'h3F80, 10'd127, 9'd0,    9'd0,    7'h01, 16'h8000);

        bus.flp_a = 16'h0;
        bus.flp_b = 16'h0;
        #1;
        check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back issue: every vector is a distinct operand pair one cycle apart.
        for (int i = 0; i < ntbl; i++) step(1'b1, tbl[i]);
        drain();

        // Fill the pipeline, then reset between edges.
        step(1'b1, tbl[0]);
        step(1'b1, tbl[2]);
        step(1'b1, tbl[3]);
        #2;
        rst = 1'b1;
        #1;
        check_zero("rst_async");
        sb.delete();
        @(posedge clk);
        #1;
        check_zero("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, tbl[11]);
        step(1'b1, tbl[6]);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
